clk_div_gen: RTL

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_ch.sv | 80 ++++++++
 rtl/clk_div_gen.sv | 99 +++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types for the clock divider: default divisor type and lock FSM states.
package clk_div_pkg;

    localparam int DIV_W_DEF = 8;

    typedef logic [DIV_W_DEF-1:0] div_t;

    typedef enum logic [1:0] {
        LS_WAIT,
        LS_PEND,
        LS_LOCKED
    } lock_state_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadow/active divisor pair with a
// pending flag, and registered enable-pulse and square-wave outputs.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 4
) (
    input  logic             clk_in,
    input  logic             resetn,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             ch_en,
    output logic             clk_en,
    output logic             clk_out,
    output logic             pending
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] active_reg;
    logic [DIV_W-1:0] shadow_reg;
    logic             pending_reg;
    logic             clk_en_reg;
    logic             clk_out_reg;

    logic [DIV_W-1:0] d_eff;
    logic [DIV_W:0]   half_d;
    logic             terminal;
    logic             below_half;
    logic             is_one;
    logic             adopt;

    // Effective divisor (0 behaves as 1), terminal count and high-phase test.
    // A load arriving in the same cycle blocks adoption so the boundary keeps
    // the old divisor and the freshly written shadow is taken next time.
    always_comb begin
        d_eff      = (active_reg == '0) ? DIV_W'(1) : active_reg;
        half_d     = ({1'b0, d_eff} + (DIV_W+1)'(1)) >> 1;
        terminal   = (cnt_reg == (d_eff - DIV_W'(1)));
        below_half = ({1'b0, cnt_reg} < half_d);
        is_one     = (d_eff == DIV_W'(1));
        adopt      = pending_reg && !div_load && (!ch_en || terminal);
    end

    // Counter, outputs and divisor bookkeeping.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            cnt_reg     <= '0;
            active_reg  <= DIV_W'(RESET_DIV);
            shadow_reg  <= DIV_W'(RESET_DIV);
            pending_reg <= 1'b0;
            clk_en_reg  <= 1'b0;
            clk_out_reg <= 1'b0;
        end else begin
            if (ch_en) begin
                clk_en_reg  <= terminal;
                clk_out_reg <= below_half && !is_one;
                cnt_reg     <= terminal ? '0 : cnt_reg + DIV_W'(1);
            end else begin
                clk_en_reg  <= 1'b0;
                clk_out_reg <= 1'b0;
                cnt_reg     <= '0;
            end
            if (adopt) begin
                active_reg <= shadow_reg;
            end
            if (div_load) begin
                shadow_reg  <= div_in;
                pending_reg <= 1'b1;
            end else if (adopt) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign clk_en  = clk_en_reg;
    assign clk_out = clk_out_reg;
    assign pending = pending_reg;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable generator with a lock indicator that asserts
// once every channel has adopted its committed divisor and settled.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DIV_W       = 8,
    parameter int RESET_DIV   = 4,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                  clk_in,
    input  logic                  resetn,
    input  logic [N_CH*DIV_W-1:0] div_in,
    input  logic                  div_load,
    input  logic [N_CH-1:0]       ch_en,
    output logic [N_CH-1:0]       clk_en,
    output logic [N_CH-1:0]       clk_out,
    output logic                  locked
);

    localparam int LCW = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW:0]   LOCK_FULL = (LCW+1)'(LOCK_CYCLES);
    localparam logic [LCW-1:0] LOCK_SAT  = LCW'(LOCK_CYCLES);

    logic [N_CH-1:0] pend_vec;
    logic            any_pending;

    lock_state_t     lock_state_reg;
    logic [LCW-1:0]  lock_cnt_reg;
    logic            locked_reg;
    logic [LCW:0]    lock_sum;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            clk_div_ch #(
                .DIV_W     (DIV_W),
                .RESET_DIV (RESET_DIV)
            ) u_ch (
                .clk_in   (clk_in),
                .resetn   (resetn),
                .div_in   (div_in[gi*DIV_W +: DIV_W]),
                .div_load (div_load),
                .ch_en    (ch_en[gi]),
                .clk_en   (clk_en[gi]),
                .clk_out  (clk_out[gi]),
                .pending  (pend_vec[gi])
            );
        end
    endgenerate

    // Pending summary and the next lock count value (one wider so it cannot wrap).
    always_comb begin
        any_pending = |pend_vec;
        lock_sum    = {1'b0, lock_cnt_reg} + (LCW+1)'(1);
    end

    // Lock FSM: a load always forces PEND; WAIT counts settled cycles up to the
    // saturating limit, LOCKED holds until the next load.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            lock_state_reg <= LS_WAIT;
            lock_cnt_reg   <= '0;
            locked_reg     <= 1'b0;
        end else if (div_load) begin
            lock_state_reg <= LS_PEND;
            locked_reg     <= 1'b0;
        end else begin
            case (lock_state_reg)
                LS_WAIT: begin
                    if (lock_sum >= LOCK_FULL) begin
                        lock_cnt_reg   <= LOCK_SAT;
                        lock_state_reg <= LS_LOCKED;
                        locked_reg     <= 1'b1;
                    end else begin
                        lock_cnt_reg <= lock_sum[LCW-1:0];
                    end
                end
                LS_PEND: begin
                    if (!any_pending) begin
                        lock_cnt_reg   <= '0;
                        lock_state_reg <= LS_WAIT;
                    end
                end
                LS_LOCKED: begin
                    locked_reg <= 1'b1;
                end
                default: begin
                    lock_state_reg <= LS_WAIT;
                    lock_cnt_reg   <= '0;
                    locked_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign locked = locked_reg;

endmodule
